// File: rtl/shift_right_multipass_if.sv
// ---------------------------------------------------------------------------
// shift_right_multipass_if
//   Request/result bundle for the multipass symbol right-shifter.
//
//   Request channel (valid/ready):
//     in_valid, in_ready, in_data, in_shift, in_fill
//   Result channel (valid/ready):
//     out_valid, out_ready, out_data, out_clamped, out_passes
//
//   modport slave  : the shifter itself (accepts requests, returns results)
//   modport master : the requester/consumer driving the shifter
// ---------------------------------------------------------------------------
interface shift_right_multipass_if #(
  parameter int NUM_SYMBOLS    = 10,
  parameter int SYMBOL_WIDTH   = 5,
  parameter int SHIFT_IN_WIDTH = 4
);

  localparam int DATA_WIDTH = NUM_SYMBOLS * SYMBOL_WIDTH;

  // Request channel
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;
  logic [SHIFT_IN_WIDTH-1:0] in_shift;
  logic [SYMBOL_WIDTH-1:0]   in_fill;

  // Result channel
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic                      out_clamped;
  logic [SHIFT_IN_WIDTH-1:0] out_passes;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_shift,
    input  in_fill,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_clamped,
    output out_passes
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_shift,
    output in_fill,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_clamped,
    input  out_passes
  );

endinterface : shift_right_multipass_if

// File: rtl/shift_right_multipass.sv
// ---------------------------------------------------------------------------
// shift_right_multipass
//   Performs a right shift of an arbitrary number of symbols by iterating a
//   single-step shifter that moves at most MAX_STEP symbols per clock.
//   Vacated upper symbols are filled with the request's fill symbol. Shifts
//   larger than NUM_SYMBOLS are clamped to NUM_SYMBOLS (all-fill result) and
//   flagged on out_clamped.
//
//   Ports:
//     clk  : sole clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : shift_right_multipass_if.slave
//            request  - in_valid/in_ready, in_data, in_shift, in_fill
//            result   - out_valid/out_ready, out_data, out_clamped,
//                       out_passes
//
//   Flow: IDLE accepts one request, SHIFT applies one pass per clock until
//   the remaining distance is zero, DONE holds the result until out_ready.
//   There is always one IDLE cycle between results.
// ---------------------------------------------------------------------------
module shift_right_multipass #(
  parameter int NUM_SYMBOLS    = 10,
  parameter int SYMBOL_WIDTH   = 5,
  parameter int MAX_STEP       = 4,
  parameter int SHIFT_IN_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_right_multipass_if.slave bus
);

  localparam int DATA_WIDTH = NUM_SYMBOLS * SYMBOL_WIDTH;

  // Constants at the width of the shift counter so compares stay width-clean.
  localparam logic [SHIFT_IN_WIDTH-1:0] NUM_SYMBOLS_W = SHIFT_IN_WIDTH'(NUM_SYMBOLS);
  localparam logic [SHIFT_IN_WIDTH-1:0] MAX_STEP_W    = SHIFT_IN_WIDTH'(MAX_STEP);
  localparam logic [SHIFT_IN_WIDTH-1:0] ONE_W         = SHIFT_IN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                    state_q,     state_d;
  logic [DATA_WIDTH-1:0]     data_q,      data_d;
  logic [SYMBOL_WIDTH-1:0]   fill_q,      fill_d;
  logic [SHIFT_IN_WIDTH-1:0] remaining_q, remaining_d;
  logic [SHIFT_IN_WIDTH-1:0] passes_q,    passes_d;
  logic                      clamped_q,   clamped_d;
  logic                      out_valid_q, out_valid_d;

  // -------------------------------------------------------------------------
  // Single-pass shifter
  //   The data register is concatenated above a vector made entirely of the
  //   fill symbol; shifting the pair right by step symbols pulls fill into
  //   the vacated top positions in one operation.
  // -------------------------------------------------------------------------
  logic [SHIFT_IN_WIDTH-1:0] step;
  logic [2*DATA_WIDTH-1:0]   shift_wide;
  logic [2*DATA_WIDTH-1:0]   shifted_wide;
  logic [DATA_WIDTH-1:0]     shifted_data;

  always_comb begin
    step         = (remaining_q > MAX_STEP_W) ? MAX_STEP_W : remaining_q;
    shift_wide   = {{NUM_SYMBOLS{fill_q}}, data_q};
    shifted_wide = shift_wide >> (int'(step) * SYMBOL_WIDTH);
    shifted_data = shifted_wide[DATA_WIDTH-1:0];
  end

  // Accept only from IDLE and never while reset is asserted.
  logic in_ready;
  assign in_ready = (state_q == IDLE) && !rst;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic [SHIFT_IN_WIDTH-1:0] accept_remaining;
  logic                      accept_clamped;

  always_comb begin
    // NOTE: every signal written here starts from its held value so no path
    // leaves it unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    data_d      = data_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    passes_d    = passes_q;
    clamped_d   = clamped_q;
    out_valid_d = out_valid_q;

    accept_clamped   = (bus.in_shift > NUM_SYMBOLS_W);
    accept_remaining = accept_clamped ? NUM_SYMBOLS_W : bus.in_shift;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          data_d      = bus.in_data;
          fill_d      = bus.in_fill;
          remaining_d = accept_remaining;
          clamped_d   = accept_clamped;
          passes_d    = '0;
          // A zero-distance request skips the shifter entirely.
          if (accept_remaining == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d     = SHIFT;
          end
        end
      end

      SHIFT: begin
        data_d      = shifted_data;
        remaining_d = remaining_q - step;
        passes_d    = passes_q + ONE_W;
        if (remaining_q == step) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        // Result registers are left untouched so outputs stay stable under
        // backpressure; the next request waits for the IDLE cycle.
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data register is reset as well, because out_data is
      // observable and must read zero after reset or an aborted request.
      state_q     <= IDLE;
      data_q      <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      passes_q    <= '0;
      clamped_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q     <= state_d;
      data_q      <= data_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      passes_q    <= passes_d;
      clamped_q   <= clamped_d;
      out_valid_q <= out_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_clamped = clamped_q;
  assign bus.out_passes  = passes_q;

endmodule : shift_right_multipass

// File: tb/tb_shift_right_multipass.sv
// ---------------------------------------------------------------------------
// tb_shift_right_multipass
//   Self-checking bench for shift_right_multipass. Expected vectors come
//   from a symbol-array model of the shift rule; pass counts and latency
//   come from ceil(min(s,N)/MAX_STEP).
// ---------------------------------------------------------------------------
module tb_shift_right_multipass;

  localparam int N   = 10;
  localparam int SW  = 5;
  localparam int MS  = 4;
  localparam int SIW = 4;
  localparam int DW  = N * SW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_right_multipass_if #(
    .NUM_SYMBOLS   (N),
    .SYMBOL_WIDTH  (SW),
    .SHIFT_IN_WIDTH(SIW)
  ) bus ();

  shift_right_multipass #(
    .NUM_SYMBOLS   (N),
    .SYMBOL_WIDTH  (SW),
    .MAX_STEP      (MS),
    .SHIFT_IN_WIDTH(SIW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] pattern();
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'(i);
    return v;
  endfunction

  function automatic int eff_shift(input int s);
    return (s > N) ? N : s;
  endfunction

  function automatic int model_passes(input int s);
    return (eff_shift(s) + MS - 1) / MS;
  endfunction

  function automatic logic [DW-1:0] model_shift(input logic [DW-1:0] d, input int s,
                                                input logic [SW-1:0] f);
    logic [SW-1:0] sym_in  [N];
    logic [SW-1:0] sym_out [N];
    logic [DW-1:0] r;
    int e;
    e = eff_shift(s);
    for (int i = 0; i < N; i++) sym_in[i] = d[i*SW +: SW];
    for (int i = 0; i < N; i++) sym_out[i] = (i + e < N) ? sym_in[i + e] : f;
    for (int i = 0; i < N; i++) r[i*SW +: SW] = sym_out[i];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers (no comparisons here)
  // ---------------------------------------------------------------------------
  // Presents one request, scrambles in_* right after the accepting edge, and
  // waits for out_valid. Returns at the negedge where out_valid was seen.
  task automatic send(input logic [DW-1:0] d, input int s, input logic [SW-1:0] f,
                      output bit acc, output bit ok, output int lat,
                      output logic [DW-1:0] od, output logic oc,
                      output logic [SIW-1:0] op);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shift = SIW'(s);
    bus.in_fill  = f;
    acc = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = DW'({$urandom(), $urandom()});
    bus.in_shift = SIW'($urandom());
    bus.in_fill  = SW'($urandom());
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    od = bus.out_data;
    oc = bus.out_clamped;
    op = bus.out_passes;
  endtask

  // Accepts the current result; samples out_valid/in_ready one cycle later.
  task automatic pop(output logic v_after, output logic r_after);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    v_after = bus.out_valid;
    r_after = bus.in_ready;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario: one full request compared against the model
  // ---------------------------------------------------------------------------
  task automatic run_request(input string name, input logic [DW-1:0] d, input int s,
                             input logic [SW-1:0] f, output logic [DW-1:0] od_out);
    bit acc, ok;
    int lat;
    logic [DW-1:0] od;
    logic oc, v_after, r_after;
    logic [SIW-1:0] op;
    logic [DW-1:0] exp_d;

    send(d, s, f, acc, ok, lat, od, oc, op);
    exp_d  = model_shift(d, s, f);
    od_out = od;

    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: in_ready=%0b required 1", name, acc);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid not seen within 20 cycles", name);
    end
    n_checks++;
    if (lat !== model_passes(s)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, model_passes(s));
    end
    n_checks++;
    if (od !== exp_d) begin
      n_fail++;
      $display("FAIL %s data: got %h required %h", name, od, exp_d);
    end
    n_checks++;
    if (oc !== (s > N)) begin
      n_fail++;
      $display("FAIL %s clamped: got %0b required %0b", name, oc, (s > N));
    end
    n_checks++;
    if (op !== SIW'(model_passes(s))) begin
      n_fail++;
      $display("FAIL %s passes: got %0d required %0d", name, op, model_passes(s));
    end

    pop(v_after, r_after);
    n_checks++;
    if (v_after !== 1'b0 || r_after !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%0b in_ready=%0b required 0 and 1",
               name, v_after, r_after);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shift  = '0;
    bus.in_fill   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready_high: got %0b required 0", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_clamped !== 1'b0 ||
        bus.out_passes !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b data=%h clamped=%0b passes=%0d required all 0",
               bus.out_valid, bus.out_data, bus.out_clamped, bus.out_passes);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready_low: got %0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_zero_shift();
    logic [DW-1:0] od;
    run_request("zero_shift", pattern(), 0, 5'h1F, od);
    n_checks++;
    if (od !== pattern()) begin
      n_fail++;
      $display("FAIL zero_shift_identity: got %h required %h", od, pattern());
    end
  endtask

  task automatic test_shift6();
    logic [DW-1:0] od, exp_d;
    for (int i = 0; i < N; i++) exp_d[i*SW +: SW] = (i < 4) ? SW'(i + 6) : 5'h0A;
    run_request("shift6", pattern(), 6, 5'h0A, od);
    n_checks++;
    if (od !== exp_d) begin
      n_fail++;
      $display("FAIL shift6_literal: got %h required %h", od, exp_d);
    end
  endtask

  task automatic test_full_and_clamp();
    logic [DW-1:0] od;
    run_request("shift10", pattern(), 10, 5'h0C, od);
    n_checks++;
    if (od !== {N{5'h0C}}) begin
      n_fail++;
      $display("FAIL shift10_all_fill: got %h required %h", od, {N{5'h0C}});
    end
    run_request("shift13", pattern(), 13, 5'h05, od);
    n_checks++;
    if (od !== {N{5'h05}}) begin
      n_fail++;
      $display("FAIL shift13_all_fill: got %h required %h", od, {N{5'h05}});
    end
  endtask

  task automatic test_backpressure();
    bit acc, ok;
    int lat;
    logic [DW-1:0] od, exp_d;
    logic oc, v_after, r_after;
    logic [SIW-1:0] op;
    int bad;

    send(pattern(), 4, 5'h03, acc, ok, lat, od, oc, op);
    exp_d = model_shift(pattern(), 4, 5'h03);
    n_checks++;
    if (!ok || lat !== 1 || od !== exp_d || op !== SIW'(1) || oc !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_result: ok=%0b lat=%0d data=%h passes=%0d clamped=%0b required 1 1 %h 1 0",
               ok, lat, od, op, oc, exp_d);
    end

    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        bus.in_valid = 1'b1;
        bus.in_data  = ~pattern();
        bus.in_shift = '0;
        bus.in_fill  = 5'h11;
      end
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== od || bus.out_clamped !== oc ||
          bus.out_passes !== op || bus.in_ready !== 1'b0) bad++;
      bus.in_valid = 1'b0;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
    end

    pop(v_after, r_after);
    n_checks++;
    if (v_after !== 1'b0 || r_after !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0 and 1", v_after, r_after);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ignored_pulse: out_valid=%0b required 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] od;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = pattern();
    bus.in_shift = SIW'(9);
    bus.in_fill  = 5'h07;
    @(posedge clk);              // accept
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);              // first pass
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_ready_in_reset: got %0b required 0", bus.in_ready);
    end
    @(posedge clk);              // would-be second pass
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: out_valid=%0b data=%h in_ready=%0b required 0 0 1",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    run_request("after_abort", pattern(), 1, 5'h1E, od);
  endtask

  task automatic test_random();
    logic [DW-1:0] d, od;
    for (int n = 0; n < 24; n++) begin
      d = DW'({$urandom(), $urandom()});
      run_request($sformatf("random%0d", n), d, int'($urandom_range(0, 15)),
                  SW'($urandom()), od);
    end
  endtask

  initial begin
    test_reset();
    test_zero_shift();
    test_shift6();
    test_full_and_clamp();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule : tb_shift_right_multipass
